irda_nec_rx: RTL and testbench
==============================

// Module: irda_nec_rx
// PURPOSE
//  NEC-style IR frame receiver/decoder for the 50 MHz board; receive end of the IR link driven by the IR transmitter.
//  Samples the demodulated IR-receiver pin and times mark/space widths.
//  Recovers the 16-bit custom code and 16-bit data code, sent MSB first, 32 bits total.
//  Flags repeat frames and framing errors; feeds LED/segment display logic.
// PARAMETERS
//  RX_ACTIVE_LOW  1       pin level during carrier burst (mark) is 0 (HS0038-type demod)
//  T_LEAD_MARK    450000  9 ms leader mark, clk cycles
//  T_LEAD_SPACE   225000  4.5 ms leader space
//  T_REP_SPACE    112500  2.25 ms repeat-frame space
//  T_BIT_MARK     28000   0.56 ms bit / stop mark
//  T_ZERO_SPACE   28250   0.565 ms space = logic 0
//  T_ONE_SPACE    84500   1.69 ms space = logic 1
//  TOL_SHIFT      2       accept window = nominal +/- (nominal >> TOL_SHIFT), i.e. +/-25 %
//  T_TIMEOUT      600000  12 ms; width counter saturates here
// PORTS
//  clk           in   1   50 MHz clock
//  rst_n         in   1   async active-low reset
//  irda_rx       in   1   raw demodulated IR pin (asynchronous)
//  custom_code   out  16  last valid frame custom code
//  data_code     out  16  last valid frame data code
//  data_valid    out  1   1-clk pulse: new full frame latched
//  repeat_valid  out  1   1-clk pulse: repeat frame seen
//  frame_err     out  1   1-clk pulse: frame aborted
//  busy          out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset: rst_n asynchronous, active-low; clock clk.
//  Reset values: all outputs 0, state IDLE, shift reg 0, bit_cnt 0.
//  Input handling:
//   - irda_rx via 2-flop synchroniser; polarity-normalised to mark=1.
//   - Edge detect on synced mark; pin-to-edge latency 3 clk.
//  Width counter (20 bit):
//   - cleared to 1 on every edge, else +1; saturates at T_TIMEOUT.
//   - On each edge, width = count before clear; compared against windows.
//  States:
//   - IDLE: mark rise -> LEAD_MARK.
//   - LEAD_MARK: mark fall; width in LEAD_MARK window -> LEAD_SPACE, else err.
//   - LEAD_SPACE: mark rise; LEAD_SPACE window -> BIT_MARK with bit_cnt=0;
//     REP_SPACE window -> REP_STOP; else err.
//   - BIT_MARK: mark fall; BIT_MARK window -> BIT_SPACE, else err.
//   - BIT_SPACE: mark rise; ZERO window shifts in 0, ONE window shifts 1
//     (shift left, first bit ends at [31]); else err. bit_cnt+1.
//     bit_cnt==31 on accept -> STOP and data_valid, else BIT_MARK.
//   - STOP / REP_STOP: mark fall -> IDLE (stop-mark width not checked).
//     REP_STOP fall pulses repeat_valid.
//  data_valid timing: same cycle custom_code<=sr[31:16] and data_code<=sr[15:0]
//   are updated; both held until the next valid frame.
//  Errors and timeouts:
//   - err: frame_err pulse, -> IDLE, codes unchanged, shift reg discarded.
//   - Counter reaching T_TIMEOUT in any non-IDLE state -> err.
//   - In IDLE, saturation only; no error.
//   - Mark rise in IDLE during a stuck-mark condition is not re-armed until a fall occurs.
//  Boundaries:
//   - Windows inclusive both ends.
//   - LEAD_SPACE check order: the lead-space and repeat-space windows are disjoint.
//  Reset mid-frame: immediate return to IDLE, outputs 0.
// STRUCTURE
//  Package irda_nec_pkg: T_* timing constants (shared with transmitter),
//   state localparams, win_ok(width,nominal) function.
//  Sub-module irda_pulse_meter: synchroniser + edge detect + saturating width counter;
//   outputs mark_rise, mark_fall, width[19:0].
//  Top: FSM + 32-bit shift register + output registers.
// TESTING
//  1. Nominal frame 0x1234_1111 at exact timings -> one data_valid,
//     custom_code=16'h1234, data_code=16'h1111, frame_err never set.
//  2. Frame 0x1234_3333, all widths +20 % -> accepted; all widths +30 % -> frame_err at the leader fall, codes unchanged.
//  3. Repeat frame (9 ms mark, 2.25 ms space, 0.56 ms mark) -> repeat_valid pulse, no data_valid, codes held.
//  4. Frame truncated after 20 bits, pin idle -> frame_err 12 ms after last edge, busy drops.
//  5. rst_n low during bit 10, then full frame 0x1234_2222 -> outputs 0 in reset, then valid 0x1234/0x2222.
//  6. Back-to-back frames 108 ms apart with different data -> two data_valid, codes track each.

Source files
------------

// File: rtl/irda_nec_pkg.sv
// NEC IR link shared definitions: timing constants (clk cycles at 50 MHz),
// receiver FSM states and the tolerance window check.
package irda_nec_pkg;

  localparam logic [19:0] T_LEAD_MARK  = 20'd450000;
  localparam logic [19:0] T_LEAD_SPACE = 20'd225000;
  localparam logic [19:0] T_REP_SPACE  = 20'd112500;
  localparam logic [19:0] T_BIT_MARK   = 20'd28000;
  localparam logic [19:0] T_ZERO_SPACE = 20'd28250;
  localparam logic [19:0] T_ONE_SPACE  = 20'd84500;
  localparam logic [19:0] T_TIMEOUT    = 20'd600000;
  localparam int          TOL_SHIFT    = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD_MARK,
    ST_LEAD_SPACE,
    ST_BIT_MARK,
    ST_BIT_SPACE,
    ST_STOP,
    ST_REP_STOP
  } state_e;

  // Inclusive window: nominal +/- (nominal >> TOL_SHIFT)
  function automatic logic win_ok(
    input logic [19:0] width,
    input logic [19:0] nominal
  );
    logic [19:0] d;
    d = nominal >> TOL_SHIFT;
    return (width >= nominal - d) &&
           (width <= nominal + d);
  endfunction

endpackage

// File: rtl/irda_nec_if.sv
// Receiver-side bundle: raw IR pin in, decoded frame
// results and status pulses out.
interface irda_nec_if;
  logic        irda_rx;
  logic [15:0] custom_code;
  logic [15:0] data_code;
  logic        data_valid;
  logic        repeat_valid;
  logic        frame_err;
  logic        busy;

  modport master (
    input  irda_rx,
    output custom_code, data_code,
    output data_valid, repeat_valid,
    output frame_err, busy
  );

  modport slave (
    output irda_rx,
    input  custom_code, data_code,
    input  data_valid, repeat_valid,
    input  frame_err, busy
  );
endinterface

// File: rtl/irda_pulse_meter.sv
// IR pin synchroniser, mark edge detector and saturating
// width counter; edges and width appear 3 clk after the pin.
module irda_pulse_meter #(
  parameter bit          RX_ACTIVE_LOW = 1'b1,
  parameter logic [19:0] T_TIMEOUT =
    irda_nec_pkg::T_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        irda_rx,
  output logic        mark_rise,
  output logic        mark_fall,
  output logic        timeout,
  output logic [19:0] width
);
  import irda_nec_pkg::*;

  logic        w_mark;
  logic        w_rise;
  logic        w_fall;
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic        r_rise;
  logic        r_fall;
  logic [19:0] r_cnt;
  logic [19:0] r_width;

  assign w_mark = RX_ACTIVE_LOW ? ~irda_rx : irda_rx;
  assign w_rise = r_s2 & ~r_s3;
  assign w_fall = ~r_s2 & r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
      r_width <= '0;
    end else begin
      r_s1   <= w_mark;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= w_rise;
      r_fall <= w_fall;
      // Width is the count before the clear to 1
      if (w_rise || w_fall) begin
        r_width <= r_cnt;
        r_cnt   <= 20'd1;
      end else if (r_cnt < T_TIMEOUT) begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

  assign mark_rise = r_rise;
  assign mark_fall = r_fall;
  assign width     = r_width;
  assign timeout   = (r_cnt == T_TIMEOUT);

endmodule

// File: rtl/irda_nec_rx.sv
// NEC frame receiver: leader/bit timing FSM, 32-bit MSB-first
// shift register, held codes and one-cycle status pulses.
module irda_nec_rx #(
  parameter bit          RX_ACTIVE_LOW = 1'b1,
  parameter logic [19:0] T_LEAD_MARK =
    irda_nec_pkg::T_LEAD_MARK,
  parameter logic [19:0] T_LEAD_SPACE =
    irda_nec_pkg::T_LEAD_SPACE,
  parameter logic [19:0] T_REP_SPACE =
    irda_nec_pkg::T_REP_SPACE,
  parameter logic [19:0] T_BIT_MARK =
    irda_nec_pkg::T_BIT_MARK,
  parameter logic [19:0] T_ZERO_SPACE =
    irda_nec_pkg::T_ZERO_SPACE,
  parameter logic [19:0] T_ONE_SPACE =
    irda_nec_pkg::T_ONE_SPACE,
  parameter logic [19:0] T_TIMEOUT =
    irda_nec_pkg::T_TIMEOUT
) (
  input logic        clk,
  input logic        rst_n,
  irda_nec_if.master bus
);
  import irda_nec_pkg::*;

  logic        w_rise;
  logic        w_fall;
  logic        w_sat;
  logic [19:0] w_width;
  logic        w_edge;
  logic        w_ok;
  logic        w_lsp_ok;
  logic        w_rsp_ok;
  logic        w_zero_ok;
  logic        w_one_ok;
  logic [31:0] w_sr_nxt;

  state_e      r_state;
  logic [31:0] r_sr;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_custom;
  logic [15:0] r_data;
  logic        r_dv;
  logic        r_rv;
  logic        r_err;

  irda_pulse_meter #(
    .RX_ACTIVE_LOW (RX_ACTIVE_LOW),
    .T_TIMEOUT     (T_TIMEOUT)
  ) u_meter (
    .clk       (clk),
    .rst_n     (rst_n),
    .irda_rx   (bus.irda_rx),
    .mark_rise (w_rise),
    .mark_fall (w_fall),
    .timeout   (w_sat),
    .width     (w_width)
  );

  always_comb begin
    w_lsp_ok  = win_ok(w_width, T_LEAD_SPACE);
    w_rsp_ok  = win_ok(w_width, T_REP_SPACE);
    w_zero_ok = win_ok(w_width, T_ZERO_SPACE);
    w_one_ok  = win_ok(w_width, T_ONE_SPACE);
    w_sr_nxt  = {r_sr[30:0], w_one_ok};
    w_edge    = w_rise;
    w_ok      = 1'b0;
    unique case (r_state)
      ST_LEAD_MARK: begin
        w_edge = w_fall;
        w_ok   = win_ok(w_width, T_LEAD_MARK);
      end
      ST_LEAD_SPACE: w_ok = w_lsp_ok | w_rsp_ok;
      ST_BIT_MARK: begin
        w_edge = w_fall;
        w_ok   = win_ok(w_width, T_BIT_MARK);
      end
      ST_BIT_SPACE: w_ok = w_zero_ok | w_one_ok;
      ST_STOP, ST_REP_STOP: begin
        w_edge = w_fall;
        w_ok   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_sr      <= '0;
      r_bit_cnt <= '0;
      r_custom  <= '0;
      r_data    <= '0;
      r_dv      <= 1'b0;
      r_rv      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_dv  <= 1'b0;
      r_rv  <= 1'b0;
      r_err <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_rise) r_state <= ST_LEAD_MARK;
      end else if (w_edge && w_ok) begin
        unique case (r_state)
          ST_LEAD_MARK: r_state <= ST_LEAD_SPACE;
          ST_LEAD_SPACE: begin
            unique case (1'b1)
              w_lsp_ok: begin
                r_bit_cnt <= '0;
                r_sr      <= '0;
                r_state   <= ST_BIT_MARK;
              end
              default: r_state <= ST_REP_STOP;
            endcase
          end
          ST_BIT_MARK: r_state <= ST_BIT_SPACE;
          ST_BIT_SPACE: begin
            r_sr      <= w_sr_nxt;
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd31) begin
              r_state  <= ST_STOP;
              r_dv     <= 1'b1;
              r_custom <= w_sr_nxt[31:16];
              r_data   <= w_sr_nxt[15:0];
            end else begin
              r_state <= ST_BIT_MARK;
            end
          end
          ST_STOP: r_state <= ST_IDLE;
          ST_REP_STOP: begin
            r_state <= ST_IDLE;
            r_rv    <= 1'b1;
          end
          default: r_state <= ST_IDLE;
        endcase
      end else if (w_edge || w_sat) begin
        // Bad width or stalled line: drop the frame
        r_state   <= ST_IDLE;
        r_err     <= 1'b1;
        r_sr      <= '0;
        r_bit_cnt <= '0;
      end
    end
  end

  assign bus.custom_code  = r_custom;
  assign bus.data_code    = r_data;
  assign bus.data_valid   = r_dv;
  assign bus.repeat_valid = r_rv;
  assign bus.frame_err    = r_err;
  assign bus.busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_irda_nec_rx.sv
// Scoreboard bench for irda_nec_rx with timings scaled by 1/1000;
// a segment-level protocol model predicts every output event.
module tb_irda_nec_rx;

  localparam int LM  = 450;
  localparam int LS  = 225;
  localparam int RS  = 112;
  localparam int BM  = 28;
  localparam int ZS  = 28;
  localparam int OS  = 84;
  localparam int TO  = 600;
  localparam int GAP = 700;

  localparam int K_VALID = 0;
  localparam int K_REP   = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int          kind;
    logic [15:0] cc;
    logic [15:0] dc;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;

  irda_nec_if bus();

  irda_nec_rx #(
    .RX_ACTIVE_LOW (1'b1),
    .T_LEAD_MARK   (20'd450),
    .T_LEAD_SPACE  (20'd225),
    .T_REP_SPACE   (20'd112),
    .T_BIT_MARK    (20'd28),
    .T_ZERO_SPACE  (20'd28),
    .T_ONE_SPACE   (20'd84),
    .T_TIMEOUT     (20'd600)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  ev_t         exp_q[$];
  int          seg[$];
  int          checks   = 0;
  int          failures = 0;
  logic [15:0] m_cc = '0;
  logic [15:0] m_dc = '0;
  int          g_num = 1;
  int          g_den = 1;
  bit          g_jit = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic bit inwin(input int w, input int nom);
    int t;
    t = nom / 4;
    return (w >= nom - t) && (w <= nom + t);
  endfunction

  task automatic push_ev(input int kind);
    ev_t e;
    e.kind = kind;
    e.cc   = m_cc;
    e.dc   = m_dc;
    exp_q.push_back(e);
  endtask

  // Walks alternating mark/space widths (index even = mark)
  task automatic model();
    int n, k, p, s, sp;
    logic [31:0] bits;
    bit ok;
    n = seg.size();
    k = 0;
    while (k < n) begin
      if (k % 2 == 1) begin
        k++;
        continue;
      end
      if (!inwin(seg[k], LM)) begin
        push_ev(K_ERR);
        k += 2;
        continue;
      end
      if (k + 1 >= n) break;
      s = seg[k+1];
      if (inwin(s, LS)) begin
        bits = '0;
        ok   = 1'b1;
        p    = k + 2;
        for (int j = 0; j < 32; j++) begin
          if (p + 1 >= n) begin
            ok = 1'b0;
            p  = n;
            break;
          end
          if (!inwin(seg[p], BM)) begin
            push_ev(K_ERR);
            ok = 1'b0;
            p += 2;
            break;
          end
          sp = seg[p+1];
          if (inwin(sp, ZS)) bits = {bits[30:0], 1'b0};
          else if (inwin(sp, OS)) bits = {bits[30:0], 1'b1};
          else begin
            push_ev(K_ERR);
            ok = 1'b0;
            p  = (sp >= TO) ? p + 2 : p + 4;
            break;
          end
          p += 2;
        end
        if (ok) begin
          m_cc = bits[31:16];
          m_dc = bits[15:0];
          push_ev(K_VALID);
          if (p < n && seg[p] >= TO) push_ev(K_ERR);
          p += 1;
        end
        k = p;
      end else if (inwin(s, RS)) begin
        if (k + 2 >= n) break;
        if (seg[k+2] >= TO) push_ev(K_ERR);
        else push_ev(K_REP);
        k += 3;
      end else begin
        push_ev(K_ERR);
        k += (s >= TO) ? 2 : 4;
      end
    end
  endtask

  function automatic int sc(input int nom);
    int w;
    w = nom * g_num / g_den;
    if (g_jit) w = w - w / 8 + int'($urandom_range(w / 4));
    return w;
  endfunction

  task automatic add_frame(input logic [31:0] d);
    seg.push_back(sc(LM));
    seg.push_back(sc(LS));
    for (int i = 31; i >= 0; i--) begin
      seg.push_back(sc(BM));
      seg.push_back(d[i] ? sc(OS) : sc(ZS));
    end
    seg.push_back(sc(BM));
  endtask

  task automatic drive();
    foreach (seg[i]) begin
      bus.irda_rx = (i % 2 == 0) ? 1'b0 : 1'b1;
      repeat (seg[i]) @(posedge clk);
      #1;
    end
    bus.irda_rx = 1'b1;
  endtask

  task automatic run_seq(input string name);
    model();
    drive();
    seg.delete();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin : mon
    ev_t e;
    int  act;
    if (rst_n && (bus.data_valid || bus.repeat_valid ||
                  bus.frame_err)) begin
      if ($countones({bus.data_valid, bus.repeat_valid,
                      bus.frame_err}) > 1) act = 3;
      else if (bus.data_valid) act = K_VALID;
      else if (bus.repeat_valid) act = K_REP;
      else act = K_ERR;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event got_kind=%0d exp=none",
                 act);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind", act, e.kind);
        chk("event_codes",
            {bus.custom_code, bus.data_code}, {e.cc, e.dc});
      end
    end
  end

  initial begin
    int tot, start, idx;
    logic [31:0] d;
    rst_n       = 1'b0;
    bus.irda_rx = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_custom", bus.custom_code, 0);
    chk("rst_data", bus.data_code, 0);
    chk("rst_pulses", {bus.data_valid, bus.repeat_valid,
                       bus.frame_err}, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    repeat (GAP) @(posedge clk);
    #1;

    add_frame(32'h1234_1111);
    seg.push_back(GAP);
    run_seq("nominal");
    chk("nominal_custom", bus.custom_code, 16'h1234);
    chk("nominal_data", bus.data_code, 16'h1111);

    g_num = 6; g_den = 5;
    add_frame(32'h1234_3333);
    seg.push_back(GAP);
    run_seq("plus20");
    chk("plus20_data", bus.data_code, 16'h3333);
    g_num = 13; g_den = 10;
    add_frame(32'h1234_4444);
    seg.push_back(GAP);
    run_seq("plus30");
    chk("plus30_held", bus.data_code, 16'h3333);
    g_num = 1; g_den = 1;

    seg = '{LM, RS, BM, GAP};
    run_seq("repeat");
    chk("repeat_held", bus.data_code, 16'h3333);

    // Inclusive window edges, then just outside them
    d = 32'h1234_F0C3;
    seg = '{562, 169};
    for (int i = 31; i >= 0; i--) begin
      seg.push_back((i % 2 == 0) ? 21 : 35);
      if (d[i]) seg.push_back((i % 2 == 0) ? 63 : 105);
      else seg.push_back((i % 2 == 0) ? 35 : 21);
    end
    seg.push_back(BM);
    seg.push_back(GAP);
    run_seq("bound_in");
    chk("bound_in_data", bus.data_code, 16'hF0C3);
    seg = '{338, 140, BM, GAP};
    run_seq("bound_rep");
    seg = '{LM, 141, BM, GAP, 563, LS, BM, GAP};
    run_seq("bound_out");

    seg = '{LM, LS};
    for (int i = 0; i < 19; i++) begin
      seg.push_back(BM);
      seg.push_back((i % 3 == 0) ? OS : ZS);
    end
    seg.push_back(BM);
    seg.push_back(GAP);
    model();
    void'(seg.pop_back());
    drive();
    seg.delete();
    repeat (550) @(posedge clk);
    @(negedge clk);
    chk("trunc_busy_early", bus.busy, 1);
    chk("trunc_no_early_err", exp_q.size(), 1);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++)
      @(negedge clk);
    chk("trunc_timeout_err", exp_q.size(), 0);
    chk("trunc_busy_drop", bus.busy, 0);
    repeat (GAP) @(posedge clk);
    #1;

    d = 32'h1234_2222;
    seg = '{LM, LS};
    for (int i = 31; i > 21; i--) begin
      seg.push_back(BM);
      seg.push_back(d[i] ? OS : ZS);
    end
    seg.push_back(14);
    drive();
    seg.delete();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_custom", bus.custom_code, 0);
    chk("midrst_data", bus.data_code, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_pulses", {bus.data_valid, bus.repeat_valid,
                          bus.frame_err}, 0);
    m_cc = '0;
    m_dc = '0;
    rst_n = 1'b1;
    repeat (GAP) @(posedge clk);
    #1;
    add_frame(d);
    seg.push_back(GAP);
    run_seq("after_rst");
    chk("after_rst_custom", bus.custom_code, 16'h1234);
    chk("after_rst_data", bus.data_code, 16'h2222);

    // Two frames on a 108 ms (5400 cycle) period
    add_frame(32'h1234_5A5A);
    tot = 0;
    foreach (seg[i]) tot += seg[i];
    seg.push_back(5400 - tot);
    start = seg.size();
    add_frame(32'h1234_A5A5);
    tot = 0;
    for (int i = start; i < seg.size(); i++) tot += seg[i];
    seg.push_back(5400 - tot);
    run_seq("b2b");
    chk("b2b_data", bus.data_code, 16'hA5A5);

    g_jit = 1'b1;
    for (int r = 0; r < 3; r++) begin
      d = $urandom;
      add_frame(d);
      if ($urandom_range(1) == 1) begin
        idx = int'($urandom_range(66));
        seg[idx] = int'($urandom_range(580, 3));
      end
      seg.push_back(GAP);
      run_seq("random");
      chk("random_codes", {bus.custom_code, bus.data_code},
          {m_cc, m_dc});
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
